// File: rtl/bp_lce_mem_port_arbiter.sv
// Arbitrates one cache memory port between the cache pipeline (priority) and the LCE engine,
// with a starvation timer that forces LCE priority. Optional perf counters: BP_LCE_MEM_ARB_PERF_EN.
module bp_lce_mem_port_arbiter #(
    parameter int pkt_width_p      = 32,
    parameter int rdata_width_p    = 64,
    parameter int timeout_max_p    = 4,
    parameter int perf_cnt_width_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     cache_v_i,
    input  logic [pkt_width_p-1:0]   cache_pkt_i,
    output logic                     cache_yumi_o,
    input  logic                     lce_v_i,
    input  logic [pkt_width_p-1:0]   lce_pkt_i,
    output logic                     lce_yumi_o,
    output logic                     mem_v_o,
    output logic [pkt_width_p-1:0]   mem_pkt_o,
    input  logic                     mem_ready_i,
    input  logic [rdata_width_p-1:0] mem_rdata_i,
    output logic                     cache_rdata_v_o,
    output logic                     lce_rdata_v_o,
    output logic [rdata_width_p-1:0] rdata_o,
    output logic                     cache_block_o,
    output logic                     starve_o
`ifdef BP_LCE_MEM_ARB_PERF_EN
    ,
    output logic [perf_cnt_width_p-1:0] perf_lce_stall_o,
    output logic [perf_cnt_width_p-1:0] perf_starve_o
`endif
);

    // state  | meaning
    // NORMAL | cache has priority, LCE served only when cache idle
    // STARVE | LCE forced through, cache requests held off

    typedef enum logic {e_normal, e_starve} state_e;
    typedef enum logic [1:0] {e_grant_none, e_grant_cache, e_grant_lce} grant_e;

    localparam int cnt_width_lp = $clog2(timeout_max_p + 1);
    localparam logic [cnt_width_lp-1:0] left_init_lp = cnt_width_lp'(timeout_max_p);
    localparam logic [cnt_width_lp-1:0] left_one_lp  = cnt_width_lp'(1);

    state_e                  state_r, state_n;
    grant_e                  grant_r, grant_n;
    logic [cnt_width_lp-1:0] left_r, left_n;
    logic                    lce_blocked;

    // Down-counter of blocked cycles left before STARVE; terminal count is zero.
    always_comb begin
        state_n       = state_r;
        left_n        = left_init_lp;
        cache_yumi_o  = 1'b0;
        lce_yumi_o    = 1'b0;
        mem_v_o       = 1'b0;
        cache_block_o = 1'b0;
        starve_o      = 1'b0;
        lce_blocked   = 1'b0;
        mem_pkt_o     = (state_r == e_normal && cache_v_i) ? cache_pkt_i : lce_pkt_i;

        if (reset_n_i) begin
            case (state_r)
                e_normal: begin
                    mem_v_o       = cache_v_i | lce_v_i;
                    cache_yumi_o  = cache_v_i & mem_ready_i;
                    lce_yumi_o    = lce_v_i & ~cache_v_i & mem_ready_i;
                    // With a one-cycle timeout the warning value is also the idle value.
                    cache_block_o = (left_r == left_one_lp) & ((timeout_max_p > 1) | lce_v_i);
                end
                e_starve: begin
                    mem_v_o       = lce_v_i;
                    lce_yumi_o    = lce_v_i & mem_ready_i;
                    cache_block_o = 1'b1;
                    starve_o      = 1'b1;
                end
                default: state_n = e_normal;
            endcase

            lce_blocked = lce_v_i & ~lce_yumi_o;
            if (lce_blocked)
                left_n = (left_r == '0) ? '0 : left_r - left_one_lp;

            if (state_r == e_normal && left_n == '0)
                state_n = e_starve;
            else if (state_r == e_starve && !lce_blocked)
                state_n = e_normal;
        end
    end

    always_comb begin
        grant_n = e_grant_none;
        if (cache_yumi_o)
            grant_n = e_grant_cache;
        else if (lce_yumi_o)
            grant_n = e_grant_lce;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= e_normal;
            grant_r <= e_grant_none;
            left_r  <= left_init_lp;
        end else begin
            state_r <= state_n;
            grant_r <= grant_n;
            left_r  <= left_n;
        end
    end

    assign cache_rdata_v_o = reset_n_i & (grant_r == e_grant_cache);
    assign lce_rdata_v_o   = reset_n_i & (grant_r == e_grant_lce);
    assign rdata_o         = mem_rdata_i;

`ifdef BP_LCE_MEM_ARB_PERF_EN
    logic [perf_cnt_width_p-1:0] stall_cnt_r, starve_cnt_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            stall_cnt_r  <= '0;
            starve_cnt_r <= '0;
        end else begin
            if (lce_blocked && stall_cnt_r != '1)
                stall_cnt_r <= stall_cnt_r + 1'b1;
            if (state_r == e_normal && state_n == e_starve && starve_cnt_r != '1)
                starve_cnt_r <= starve_cnt_r + 1'b1;
        end
    end

    assign perf_lce_stall_o = stall_cnt_r;
    assign perf_starve_o    = starve_cnt_r;
`endif

endmodule

// File: tb/tb_bp_lce_mem_port_arbiter.sv
// Directed bench for bp_lce_mem_port_arbiter: expected outputs queued per cycle, checked by a monitor.
module tb_bp_lce_mem_port_arbiter;

    localparam int pw_lp = 8;
    localparam int rw_lp = 8;
    localparam logic [7:0] cp_lp = 8'hA5;
    localparam logic [7:0] lp_lp = 8'h3C;

    logic             clk;
    logic             reset_n;
    logic             cache_v, lce_v, mem_ready;
    logic [pw_lp-1:0] cache_pkt, lce_pkt, mem_pkt;
    logic             cache_yumi, lce_yumi, mem_v;
    logic [rw_lp-1:0] mem_rdata, rdata;
    logic             cache_rdata_v, lce_rdata_v, cache_block, starve;
`ifdef BP_LCE_MEM_ARB_PERF_EN
    logic [15:0]      perf_lce_stall, perf_starve;
`endif

    bp_lce_mem_port_arbiter #(
        .pkt_width_p(pw_lp), .rdata_width_p(rw_lp), .timeout_max_p(4), .perf_cnt_width_p(16)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .cache_v_i(cache_v), .cache_pkt_i(cache_pkt), .cache_yumi_o(cache_yumi),
        .lce_v_i(lce_v), .lce_pkt_i(lce_pkt), .lce_yumi_o(lce_yumi),
        .mem_v_o(mem_v), .mem_pkt_o(mem_pkt), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
        .cache_rdata_v_o(cache_rdata_v), .lce_rdata_v_o(lce_rdata_v), .rdata_o(rdata),
        .cache_block_o(cache_block), .starve_o(starve)
`ifdef BP_LCE_MEM_ARB_PERF_EN
        , .perf_lce_stall_o(perf_lce_stall), .perf_starve_o(perf_starve)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] v;
        string       name;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         failed = 0;
    logic [7:0] md_seq = 8'h40;

    // {cache_yumi, lce_yumi, mem_v, mem_pkt, cache_rdata_v, lce_rdata_v, rdata, cache_block, starve}
    task automatic step(input logic r, cv, lv, rdy,
                        input logic cy, ly, mv, input logic [7:0] pkt,
                        input logic crv, lrv, blk, stv, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n   = r;
        cache_v   = cv;
        lce_v     = lv;
        mem_ready = rdy;
        mem_rdata = md_seq;
        e.v    = {cy, ly, mv, pkt, crv, lrv, md_seq, blk, stv};
        e.name = nm;
        sb.push_back(e);
        md_seq = md_seq + 8'd1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t        e;
                logic [22:0] act;
                e   = sb.pop_front();
                act = {cache_yumi, lce_yumi, mem_v, mem_pkt, cache_rdata_v, lce_rdata_v,
                       rdata, cache_block, starve};
                tests++;
                if (act !== e.v) begin
                    failed++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.v);
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        cache_v   = 1'b1;
        lce_v     = 1'b1;
        mem_ready = 1'b1;
        cache_pkt = cp_lp;
        lce_pkt   = lp_lp;
        mem_rdata = 8'h00;

        // reset held with both requesters valid
        step(0,1,1,1, 0,0,0,cp_lp, 0,0,0,0, "reset_1");
        step(0,1,1,1, 0,0,0,cp_lp, 0,0,0,0, "reset_2");
        step(0,1,1,1, 0,0,0,cp_lp, 0,0,0,0, "reset_3");

        // cache only
        step(1,1,0,1, 1,0,1,cp_lp, 0,0,0,0, "cache_grant");
        step(1,0,0,1, 0,0,0,lp_lp, 1,0,0,0, "cache_rdata");

        // lce only
        step(1,0,1,1, 0,1,1,lp_lp, 0,0,0,0, "lce_grant");
        step(1,0,0,1, 0,0,0,lp_lp, 0,1,0,0, "lce_rdata");

        // both valid: four cache grants, warning, starve, back to normal
        step(1,1,1,1, 1,0,1,cp_lp, 0,0,0,0, "both_c1");
        step(1,1,1,1, 1,0,1,cp_lp, 1,0,0,0, "both_c2");
        step(1,1,1,1, 1,0,1,cp_lp, 1,0,0,0, "both_c3");
        step(1,1,1,1, 1,0,1,cp_lp, 1,0,1,0, "both_c4_warn");
        step(1,1,1,1, 0,1,1,lp_lp, 1,0,1,1, "both_c5_starve");
        step(1,1,1,1, 1,0,1,cp_lp, 0,1,0,0, "both_c6_normal");
        step(1,0,0,1, 0,0,0,lp_lp, 1,0,0,0, "both_idle");

        // starve while memory not ready
        step(1,1,1,1, 1,0,1,cp_lp, 0,0,0,0, "nr_c1");
        step(1,1,1,1, 1,0,1,cp_lp, 1,0,0,0, "nr_c2");
        step(1,1,1,1, 1,0,1,cp_lp, 1,0,0,0, "nr_c3");
        step(1,1,1,1, 1,0,1,cp_lp, 1,0,1,0, "nr_c4_warn");
        step(1,1,1,0, 0,0,1,lp_lp, 1,0,1,1, "nr_starve_1");
        step(1,1,1,0, 0,0,1,lp_lp, 0,0,1,1, "nr_starve_2");
        step(1,1,1,0, 0,0,1,lp_lp, 0,0,1,1, "nr_starve_3");
        step(1,1,1,1, 0,1,1,lp_lp, 0,0,1,1, "nr_starve_grant");
        step(1,1,0,1, 1,0,1,cp_lp, 0,1,0,0, "nr_normal");

        // reset one cycle after a grant, with the counter part-way
        step(1,1,1,1, 1,0,1,cp_lp, 1,0,0,0, "rg_c1");
        step(1,1,1,1, 1,0,1,cp_lp, 1,0,0,0, "rg_c2");
        step(1,1,1,1, 1,0,1,cp_lp, 1,0,0,0, "rg_c3");
        step(0,1,1,1, 0,0,0,cp_lp, 0,0,0,0, "rg_reset");
        step(1,1,1,1, 1,0,1,cp_lp, 0,0,0,0, "rg_after_1");
        step(1,1,1,1, 1,0,1,cp_lp, 1,0,0,0, "rg_after_2");
        step(1,1,1,1, 1,0,1,cp_lp, 1,0,0,0, "rg_after_3");
        step(1,1,1,1, 1,0,1,cp_lp, 1,0,1,0, "rg_after_warn");
        step(1,1,1,1, 0,1,1,lp_lp, 1,0,1,1, "rg_after_starve");
        step(1,0,0,1, 0,0,0,lp_lp, 0,1,0,0, "rg_after_idle");

        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
